bundle_stream_ctrl: RTL and testbench
=====================================

Name: bundle_stream_ctrl

Overview:
- Multi-core successor of the hypervector bundling buffer: per-dimension signed majority counters accumulate core results from up to CORENUM cores per cycle.
- On a finish request, the block snapshots the sign vector with tie-break into a shadow register, then streams it in OUT_W-bit beats over a valid/ready handshake.
- Accumulation of the next vector overlaps streaming of the previous one.
- Sits between the core array and the output DMA stream.

Parameters:
- DIM, 1023, MSB index of a hypervector; vector width is DIM+1.
- CORENUM, 4, number of cores; one result lane and one store bit per core.
- CNT_W, 30, counter width, signed two's complement. Must satisfy CNT_W >= clog2(CORENUM)+2.
- OUT_W, 64, stream beat width. (DIM+1) must be a multiple of OUT_W. BEATS = (DIM+1)/OUT_W.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- core_result, in, CORENUM*(DIM+1), lane k occupies bits [k*(DIM+1)+DIM : k*(DIM+1)].
- store, in, CORENUM, store[k]=1 means lane k is valid this cycle.
- clear, in, 1, zeroes all counters and the overflow flag.
- start, in, 1, finish request; honoured only in IDLE.
- tmp_even, in, 1, sampled with start; selects the tie-break mode.
- tmp_rand, in, DIM+1, sampled with start; tie-break bits.
- busy, out, 1, high when state is not IDLE.
- m_valid, out, 1, stream beat valid.
- m_ready, in, 1, downstream ready.
- m_data, out, OUT_W, stream beat data.
- m_last, out, 1, high on the final beat.
- overflow, out, 1, sticky; set when any counter saturates.

Behaviour:
- Reset (rst=0 at a clk edge):
  - counters=0, shadow=0, state=IDLE.
  - busy=0, m_valid=0, m_data=0, m_last=0, overflow=0.
  - Reset mid-stream aborts the stream with no further beats.
- Accumulation, evaluated every cycle in every state, per bit i:
  - delta_i = sum over k with store[k]=1 of (+1 if lane k bit i is 1, else -1).
  - Range of delta_i is [-CORENUM, +CORENUM].
  - cnt_i <= sat(cnt_i + delta_i), where sat clamps to [-(2^(CNT_W-1)-1), +(2^(CNT_W-1)-1)].
  - If clamping occurs on any bit, overflow <= 1.
- clear and the SNAP restart: cnt_i <= sat(0 + delta_i). The store in that same cycle is not lost.
  - clear also zeroes overflow, unless saturation occurs in that same cycle.
  - clear does not affect the FSM or the shadow register.
- FSM states: IDLE, SNAP, STREAM.
- IDLE:
  - start=1 latches tmp_even and tmp_rand, then goes to SNAP.
  - Counter values after this edge include this cycle's store.
- SNAP (exactly 1 cycle), for each bit i, shadow_i <= 1 if cnt_i>0, 0 if cnt_i<0.
  - If cnt_i==0: shadow_i <= latched tmp_rand[i] when latched tmp_even=1, else 0.
  - Counters restart as described above. beat index <= 0. Next state is STREAM with m_valid=1.
- STREAM:
  - m_data = shadow[beat*OUT_W +: OUT_W]; m_last = (beat==BEATS-1).
  - A beat transfers when m_valid and m_ready are both 1; beat then increments.
  - A transfer with m_last=1 drops m_valid and returns to IDLE.
  - m_data is held stable while m_valid=1 and m_ready=0.
- start outside IDLE is ignored (no queuing). start and clear in the same IDLE cycle: clear applies first, then the snapshot sees the freshly restarted counters.
- Latency: start at edge E0 → SNAP during cycle E0..E1 → m_valid=1 after E1. Minimum time from start to IDLE is BEATS+2 edges.
- Outside STREAM, m_data is held at its last value and m_last=0.

Test Plan:
- DIM=7, CORENUM=2, OUT_W=4. Stores as (lane0, lane1, store): 3x (8'hF0, 8'hF0, 2'b11), then 1x (8'h0F, 0, 2'b01), then start with tmp_even=0, m_ready=1 → cnt high nibble=+5, low nibble=-5; beat0 m_data=4'h0, beat1 m_data=4'hF with m_last=1; busy falls 4 edges after start.
- Tie case: one store (8'hAA, 8'h55, 2'b11) so all counters are 0; start with tmp_even=1, tmp_rand=8'h3C → stream 4'hC then 4'h3. Repeat with tmp_even=0 → stream 4'h0 then 4'h0.
- Backpressure: hold m_ready=0 for 5 cycles during beat0 → m_valid stays 1, m_data is stable, beat does not advance. Release m_ready → both beats arrive in order.
- Overlap: store 8'hFF on lane0 during the SNAP cycle and during STREAM, then issue a second start → the second vector is 8'hFF. The first stream is unaffected.
- Saturation: CNT_W=4, 9 stores of (8'hFF, 8'hFF, 2'b11) → counters clamp at +7 and overflow=1. Assert clear → overflow=0 and counters=0. Reset asserted during STREAM → m_valid=0 on the next edge and state returns to IDLE.

Source files
------------

// File: rtl/bundle_stream_ctrl.sv
// Multi-core hypervector bundling buffer: saturating per-dimension majority counters,
// sign snapshot with tie-break into a shadow register, streamed out over valid/ready.
module bundle_stream_ctrl #(
    parameter int DIM     = 1023,
    parameter int CORENUM = 4,
    parameter int CNT_W   = 30,
    parameter int OUT_W   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CORENUM*(DIM+1)-1:0] core_result,
    input  logic [CORENUM-1:0]       store,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     tmp_even,
    input  logic [DIM:0]             tmp_rand,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_last,
    output logic                     overflow
);

    localparam int VW     = DIM + 1;
    localparam int BEATS  = VW / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SNAP   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic signed [CNT_W:0]   CNT_MAX = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0]   CNT_MIN = -CNT_MAX;
    localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BEATS - 1);

    function automatic logic signed [CNT_W-1:0] sat_cnt(input logic signed [CNT_W:0] v);
        if (v > CNT_MAX)
            return CNT_MAX[CNT_W-1:0];
        else if (v < CNT_MIN)
            return CNT_MIN[CNT_W-1:0];
        else
            return v[CNT_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [CNT_W:0] v);
        return (v > CNT_MAX) || (v < CNT_MIN);
    endfunction

    logic [1:0]              state;
    logic signed [CNT_W-1:0] cnt     [VW];
    logic signed [CNT_W-1:0] cnt_nxt [VW];
    logic [VW-1:0]           clamp_v;
    logic [VW-1:0]           snap_vec;
    logic [VW-1:0]           shadow;
    logic [BEAT_W-1:0]       beat;
    logic [BEAT_W-1:0]       beat_nxt;
    logic                    even_q;
    logic [DIM:0]            rand_q;
    logic                    restart;

    // Counters restart from zero on clear and during the snapshot cycle, keeping that cycle's store.
    always_comb begin
        logic signed [CNT_W-1:0] delta;
        logic signed [CNT_W:0]   base;
        logic signed [CNT_W:0]   sum;
        restart = clear || (state == ST_SNAP);
        for (int i = 0; i < VW; i++) begin
            delta = '0;
            for (int k = 0; k < CORENUM; k++) begin
                if (store[k])
                    delta = core_result[k*VW + i] ? delta + ONE : delta - ONE;
            end
            base        = restart ? '0 : {cnt[i][CNT_W-1], cnt[i]};
            sum         = base + {delta[CNT_W-1], delta};
            cnt_nxt[i]  = sat_cnt(sum);
            clamp_v[i]  = is_sat(sum);
            if (cnt[i] == '0)
                snap_vec[i] = even_q & rand_q[i];
            else
                snap_vec[i] = ~cnt[i][CNT_W-1];
        end
    end

    assign beat_nxt = beat + 1'b1;
    assign busy     = (state != ST_IDLE);
    assign m_valid  = (state == ST_STREAM);
    assign m_last   = (state == ST_STREAM) && (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < VW; i++)
                cnt[i] <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
            shadow   <= '0;
            beat     <= '0;
            m_data   <= '0;
            even_q   <= 1'b0;
            rand_q   <= '0;
        end else begin
            for (int i = 0; i < VW; i++)
                cnt[i] <= cnt_nxt[i];
            if (|clamp_v)
                overflow <= 1'b1;
            else if (clear)
                overflow <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        even_q <= tmp_even;
                        rand_q <= tmp_rand;
                        state  <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    shadow <= snap_vec;
                    m_data <= snap_vec[OUT_W-1:0];
                    beat   <= '0;
                    state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    // m_data only advances on a transfer, so it stays stable under backpressure.
                    if (m_ready) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_IDLE;
                        end else begin
                            beat   <= beat_nxt;
                            m_data <= shadow[beat_nxt*OUT_W +: OUT_W];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bundle_stream_ctrl.sv
// Bench for bundle_stream_ctrl: directed scenarios plus random traffic checked against
// a queue-based behavioural model of counters, snapshots and the beat stream.
module tb_bundle_stream_ctrl;

    localparam int DIM     = 7;
    localparam int CORENUM = 2;
    localparam int CNT_W   = 4;
    localparam int OUT_W   = 4;
    localparam int VW      = DIM + 1;
    localparam int BEATS   = VW / OUT_W;
    localparam int CMAX    = (1 << (CNT_W - 1)) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [CORENUM*VW-1:0]      core_result;
    logic [CORENUM-1:0]         store;
    logic                       clear;
    logic                       start;
    logic                       tmp_even;
    logic [DIM:0]               tmp_rand;
    logic                       busy;
    logic                       m_valid;
    logic                       m_ready;
    logic [OUT_W-1:0]           m_data;
    logic                       m_last;
    logic                       overflow;

    bundle_stream_ctrl #(.DIM(DIM), .CORENUM(CORENUM), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .core_result(core_result), .store(store), .clear(clear),
        .start(start), .tmp_even(tmp_even), .tmp_rand(tmp_rand), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               mc [VW];
    bit               movf;
    bit               msnap;
    bit               meven;
    logic [DIM:0]     mrand;
    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] mdata;
    logic [OUT_W-1:0] got_q [$];

    task automatic model_reset();
        for (int i = 0; i < VW; i++) mc[i] = 0;
        movf  = 1'b0;
        msnap = 1'b0;
        meven = 1'b0;
        mrand = '0;
        mdata = '0;
        exp_q.delete();
    endtask

    task automatic quiet();
        core_result = '0;
        store       = '0;
        clear       = 1'b0;
        start       = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model with the inputs seen at the edge.
    task automatic step();
        bit           idle_before;
        bit           restart;
        bit           clamped;
        int           d;
        int           v;
        logic [DIM:0] vec;
        @(negedge clk);
        checks++;
        if (busy !== (msnap || exp_q.size() > 0)) begin
            errors++; $display("FAIL busy: got %b want %b", busy, (msnap || exp_q.size() > 0));
        end
        checks++;
        if (m_valid !== (exp_q.size() > 0)) begin
            errors++; $display("FAIL m_valid: got %b want %b", m_valid, (exp_q.size() > 0));
        end
        checks++;
        if (m_last !== (exp_q.size() == 1)) begin
            errors++; $display("FAIL m_last: got %b want %b", m_last, (exp_q.size() == 1));
        end
        checks++;
        if (m_data !== mdata) begin
            errors++; $display("FAIL m_data: got %h want %h", m_data, mdata);
        end
        checks++;
        if (overflow !== movf) begin
            errors++; $display("FAIL overflow: got %b want %b", overflow, movf);
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);

        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            idle_before = !msnap && (exp_q.size() == 0);
            for (int i = 0; i < VW; i++) begin
                if (mc[i] > 0)       vec[i] = 1'b1;
                else if (mc[i] < 0)  vec[i] = 1'b0;
                else                 vec[i] = meven & mrand[i];
            end
            restart = clear || msnap;
            clamped = 1'b0;
            for (int i = 0; i < VW; i++) begin
                d = 0;
                for (int k = 0; k < CORENUM; k++)
                    if (store[k]) d += core_result[k*VW + i] ? 1 : -1;
                v = (restart ? 0 : mc[i]) + d;
                if (v > CMAX)  begin v = CMAX;  clamped = 1'b1; end
                if (v < -CMAX) begin v = -CMAX; clamped = 1'b1; end
                mc[i] = v;
            end
            if (clamped)    movf = 1'b1;
            else if (clear) movf = 1'b0;
            if (exp_q.size() > 0 && m_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() > 0) mdata = exp_q[0];
            end
            if (msnap) begin
                for (int b = 0; b < BEATS; b++) exp_q.push_back(vec[b*OUT_W +: OUT_W]);
                mdata = exp_q[0];
                msnap = 1'b0;
            end else if (idle_before && start) begin
                meven = tmp_even;
                mrand = tmp_rand;
                msnap = 1'b1;
            end
        end
        #1;
    endtask

    task automatic run_to_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic do_clear();
        quiet();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic issue_start(input logic even, input logic [DIM:0] rnd);
        tmp_even = even;
        tmp_rand = rnd;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic check_beats(input string name, input logic [OUT_W-1:0] b0, input logic [OUT_W-1:0] b1);
        checks++;
        if (got_q.size() != 2 || got_q[0] !== b0 || got_q[1] !== b1) begin
            errors++;
            $display("FAIL %s: got %0d beats %h %h want %h %h", name, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 4'hx, (got_q.size() > 1) ? got_q[1] : 4'hx, b0, b1);
        end
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b0; m_ready = 1'b0; tmp_even = 1'b0; tmp_rand = '0;
        model_reset();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n;
        do_clear();
        for (int r = 0; r < 3; r++) begin
            core_result = {8'hF0, 8'hF0}; store = 2'b11; step();
        end
        core_result = {8'h00, 8'h0F}; store = 2'b01; step();
        quiet();
        m_ready = 1'b1;
        got_q.delete();
        issue_start(1'b0, 8'h00);
        run_to_idle(n);
        checks++;
        if (n + 1 != BEATS + 2) begin
            errors++; $display("FAIL start_to_idle: got %0d edges want %0d", n + 1, BEATS + 2);
        end
        check_beats("basic_beats", 4'h0, 4'hF);
    endtask

    task automatic test_tie();
        int n;
        logic mode [2];
        logic [OUT_W-1:0] e0 [2];
        logic [OUT_W-1:0] e1 [2];
        mode[0] = 1'b1; e0[0] = 4'hC; e1[0] = 4'h3;
        mode[1] = 1'b0; e0[1] = 4'h0; e1[1] = 4'h0;
        for (int t = 0; t < 2; t++) begin
            do_clear();
            core_result = {8'h55, 8'hAA}; store = 2'b11; step();
            quiet();
            m_ready = 1'b1;
            got_q.delete();
            issue_start(mode[t], 8'h3C);
            run_to_idle(n);
            check_beats(mode[t] ? "tie_even" : "tie_zero", e0[t], e1[t]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [OUT_W-1:0] held;
        do_clear();
        core_result = {8'h00, 8'h96}; store = 2'b01; step();
        quiet();
        m_ready = 1'b0;
        got_q.delete();
        issue_start(1'b0, 8'h00);
        step();
        held = m_data;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (m_valid !== 1'b1 || m_data !== held || m_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=0",
                                   m_valid, m_data, m_last, held);
            end
        end
        m_ready = 1'b1;
        run_to_idle(n);
        check_beats("bp_beats", 4'h6, 4'h9);
    endtask

    task automatic test_overlap();
        int n;
        do_clear();
        core_result = {8'h00, 8'h0F}; store = 2'b01; step();
        quiet();
        m_ready = 1'b1;
        got_q.delete();
        issue_start(1'b0, 8'h00);
        core_result = {8'h00, 8'hFF}; store = 2'b01;
        run_to_idle(n);
        check_beats("overlap_first", 4'hF, 4'h0);
        quiet();
        got_q.delete();
        issue_start(1'b0, 8'h00);
        run_to_idle(n);
        check_beats("overlap_second", 4'hF, 4'hF);
    endtask

    task automatic test_saturation();
        int n;
        do_clear();
        for (int r = 0; r < 9; r++) begin
            core_result = {8'hFF, 8'hFF}; store = 2'b11; step();
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL sat_ovf: got %b want 1", overflow);
        end
        // Clamped at +7, four -2 steps land at -1; an unclamped counter would stay positive.
        for (int r = 0; r < 4; r++) begin
            core_result = {8'h00, 8'h00}; store = 2'b11; step();
        end
        quiet();
        m_ready = 1'b1;
        got_q.delete();
        issue_start(1'b1, 8'hFF);
        run_to_idle(n);
        check_beats("sat_clamp", 4'h0, 4'h0);
        do_clear();
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL clear_ovf: got %b want 0", overflow);
        end
        got_q.delete();
        issue_start(1'b1, 8'hA5);
        run_to_idle(n);
        check_beats("clear_zero", 4'h5, 4'hA);
        m_ready = 1'b0;
        issue_start(1'b1, 8'h3C);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 4'h0) begin
            errors++; $display("FAIL reset_abort: got v=%b b=%b d=%h want 0 0 0", m_valid, busy, m_data);
        end
        step();
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 400; c++) begin
            core_result = CORENUM*VW'($urandom);
            store       = CORENUM'($urandom);
            clear       = ($urandom_range(15) == 0);
            start       = ($urandom_range(7) == 0);
            tmp_even    = 1'($urandom);
            tmp_rand    = VW'($urandom);
            m_ready     = ($urandom_range(3) != 0);
            step();
        end
        quiet();
        m_ready = 1'b1;
        run_to_idle(n);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL random_drain: got busy %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_overlap();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
